// File: rtl/traffic_light_fsm.sv
// Two-road traffic light controller: sensor-actuated greens, timed yellow
// and all-red clearance, all timing counted in upstream tick pulses.
module traffic_light_fsm #(
    parameter int unsigned GREEN_MIN = 5,
    parameter int unsigned GREEN_MAX = 15,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 1
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       sensor_a,
    input  logic       sensor_b,
    output logic [2:0] la,
    output logic [2:0] lb,
    output logic [2:0] phase,
    output logic       phase_change
);

    localparam int unsigned CNT_W = 8;

    localparam logic [CNT_W-1:0] GMIN = CNT_W'(GREEN_MIN);
    localparam logic [CNT_W-1:0] GMAX = CNT_W'(GREEN_MAX);
    localparam logic [CNT_W-1:0] YLW  = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] ARD  = CNT_W'(ALLRED_T);

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_YELLOW = 3'd1,
        ALLRED_A = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        ALLRED_B = 3'd5
    } state_e;

    state_e           state_q, state_d;
    state_e           target_c;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [CNT_W-1:0] n_c;
    logic             pc_q, pc_d;
    logic             exit_c;
    logic             illegal_c;

    // Tick count including the current tick; bounded by GREEN_MAX so never wraps.
    always_comb n_c = tcnt_q + CNT_W'(1);

    // Per-state exit condition (assuming a tick) and successor state.
    always_comb begin
        exit_c    = 1'b0;
        illegal_c = 1'b0;
        target_c  = state_q;
        case (state_q)
            A_GREEN: begin
                exit_c   = ((n_c >= GMIN) && sensor_b) || (n_c == GMAX);
                target_c = A_YELLOW;
            end
            A_YELLOW: begin
                exit_c   = (n_c == YLW);
                target_c = ALLRED_A;
            end
            ALLRED_A: begin
                exit_c   = (n_c == ARD);
                target_c = B_GREEN;
            end
            B_GREEN: begin
                exit_c   = ((n_c >= GMIN) && sensor_a) || (n_c == GMAX);
                target_c = B_YELLOW;
            end
            B_YELLOW: begin
                exit_c   = (n_c == YLW);
                target_c = ALLRED_B;
            end
            ALLRED_B: begin
                exit_c   = (n_c == ARD);
                target_c = A_GREEN;
            end
            default: begin
                illegal_c = 1'b1;
                target_c  = ALLRED_B;
            end
        endcase
    end

    // Next-state: illegal codes recover immediately; otherwise advance only on tick.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        pc_d    = 1'b0;
        if (illegal_c) begin
            state_d = ALLRED_B;
            tcnt_d  = '0;
            pc_d    = 1'b1;
        end else if (tick) begin
            if (exit_c) begin
                state_d = target_c;
                tcnt_d  = '0;
                pc_d    = 1'b1;
            end else begin
                tcnt_d  = n_c;
            end
        end
    end

    // State, dwell counter and transition pulse registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q <= ALLRED_B;
            tcnt_q  <= '0;
            pc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            pc_q    <= pc_d;
        end
    end

    // Moore lamp decode; anything not explicitly green/yellow shows red.
    always_comb begin
        la = LAMP_RED;
        lb = LAMP_RED;
        case (state_q)
            A_GREEN:  la = LAMP_GRN;
            A_YELLOW: la = LAMP_YEL;
            B_GREEN:  lb = LAMP_GRN;
            B_YELLOW: lb = LAMP_YEL;
            default: begin
                la = LAMP_RED;
                lb = LAMP_RED;
            end
        endcase
    end

    assign phase        = state_q;
    assign phase_change = pc_q;

endmodule

// File: doc/traffic_light_fsm.md
TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- GREEN_MIN, 5, minimum green duration in ticks; legal range 1..255.
- GREEN_MAX, 15, maximum green duration in ticks; legal range GREEN_MIN..255.
- YELLOW_T, 3, yellow duration in ticks; legal range 1..255.
- ALLRED_T, 1, all-red clearance duration in ticks; legal range 1..255.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk_in, in, 1, the only clock; all state updates on its rising edge.
- rst_n, in, 1, synchronous active-low reset.
- tick, in, 1, timing enable pulse from the upstream clock-divider stage, synchronous to clk_in; each cycle with tick=1 counts as one tick.
- sensor_a, in, 1, vehicle waiting on road A, synchronous to clk_in.
- sensor_b, in, 1, vehicle waiting on road B, synchronous to clk_in.
- la, out, 3, road A lamps {red,yellow,green}.
- lb, out, 3, road B lamps {red,yellow,green}.
- phase, out, 3, current state code.
- phase_change, out, 1, one-cycle pulse in the cycle after a state transition.
REQ-003 The block SHALL have one clock (clk_in) and a synchronous, active-low reset (rst_n).

Function
REQ-004 States and phase codes SHALL be: A_GREEN=0, A_YELLOW=1, ALLRED_A=2, B_GREEN=3, B_YELLOW=4, ALLRED_B=5; codes 6 and 7 are illegal.
REQ-005 Lamp encoding SHALL be: red=100, yellow=010, green=001. Lamps SHALL be decoded from the state register only (Moore outputs).
REQ-006 Lamp values per state SHALL be: A_GREEN la=001 lb=100; A_YELLOW la=010 lb=100; ALLRED_A and ALLRED_B both 100; B_GREEN la=100 lb=001; B_YELLOW la=100 lb=010.
REQ-007 An 8-bit tick counter tcnt SHALL count ticks elapsed in the current state. On a tick cycle, n=tcnt+1; when no tick occurs, state and tcnt SHALL hold.
REQ-008 Exit rule for A_GREEN on a tick: exit to A_YELLOW if (n>=GREEN_MIN and sensor_b=1) or n==GREEN_MAX. Sensors SHALL be sampled only on tick cycles. sensor_a SHALL NOT affect the A_GREEN exit.
REQ-009 Exit rule for B_GREEN on a tick: exit to B_YELLOW if (n>=GREEN_MIN and sensor_a=1) or n==GREEN_MAX; mirror of REQ-008.
REQ-010 Timed transitions on a tick:
- A_YELLOW to ALLRED_A when n==YELLOW_T.
- ALLRED_A to B_GREEN when n==ALLRED_T.
- B_YELLOW to ALLRED_B when n==YELLOW_T.
- ALLRED_B to A_GREEN when n==ALLRED_T.
REQ-011 On any transition, tcnt SHALL be cleared to 0; otherwise tcnt<=n on a tick. tcnt SHALL never wrap, because GREEN_MAX<=255 bounds it.
REQ-012 Latency: a transition triggered by tick in cycle k SHALL be visible on la/lb/phase after the clk_in edge ending cycle k. phase_change SHALL be 1 for exactly that next cycle.
REQ-013 At most one transition SHALL occur per clock cycle. A continuously high tick SHALL advance one count per cycle.
REQ-014 Safety invariant: la and lb SHALL never both be non-red in the same cycle.
REQ-015 An illegal state code SHALL go to ALLRED_B on the next edge with tcnt=0, regardless of tick. Lamps SHALL read 100/100 while in an illegal state.

Reset
REQ-016 With rst_n=0 at a clk_in edge: state=ALLRED_B, tcnt=0, la=100, lb=100, phase=5, phase_change=0.
REQ-017 Reset SHALL take priority over tick and sensors, including when asserted mid-state or in the same cycle as a transition-triggering tick.
REQ-018 After reset release, the first tick SHALL move ALLRED_B to A_GREEN (with default ALLRED_T=1).

Verification
REQ-019 Reset then release, one tick -> next cycle la=001, lb=100, phase=0, phase_change=1 for one cycle.
REQ-020 In A_GREEN with sensor_b=1 held -> la=010 after the 5th tick; la=100/lb=100 after 3 more ticks; lb=001 after 1 more tick.
REQ-021 In A_GREEN with sensor_b=0 throughout -> A_GREEN held through 14 ticks; la=010 after the 15th tick.
REQ-022 In A_GREEN with sensor_b raised only before the 9th tick -> exit on the 9th tick; confirm no exit at ticks 5-8 and that sensor pulses on non-tick cycles are ignored.
REQ-023 In B_YELLOW, rst_n=0 in the same cycle as tick with n==YELLOW_T -> next cycle state ALLRED_B, tcnt=0, phase_change=0.
REQ-024 Drive tick=1 continuously with random sensors for 10k cycles -> REQ-014 invariant never violated; each green dwell is within GREEN_MIN..GREEN_MAX cycles.
